// File: rtl/tt_equiv_checker_pkg.sv
// ---------------------------------------------------------------------------
// tt_equiv_checker_pkg
// Shared definitions for the truth-table equivalence checker: the sweep FSM
// state encoding and the largest supported number of DUT inputs.
// No ports (package).
// ---------------------------------------------------------------------------
package tt_equiv_checker_pkg;

  // Largest input count the checker is meant to sweep (16-entry truth table)
  localparam int MAX_N_IN = 4;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_settle_counter.sv
// ---------------------------------------------------------------------------
// tt_settle_counter
// Counts the cycles a stimulus vector has been held so the sequencer knows
// when the DUT outputs have settled.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, clears the count
//   i_load     restart the count at zero (has priority over i_enable)
//   i_enable   advance the count by one
//   o_terminal high while the count equals SETTLE-1
// ---------------------------------------------------------------------------
module tt_settle_counter
  import tt_equiv_checker_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // The count parks on its terminal value instead of running past it, so the
  // register only ever needs to hold 0..SETTLE-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + COUNT_ONE;
    end
  end

  assign o_terminal = (r_count == COUNT_LAST);

endmodule

// File: rtl/tt_equiv_checker.sv
// ---------------------------------------------------------------------------
// tt_equiv_checker
// Clocked stimulus/compare engine for two implementations of the same small
// combinational function. Each sweep walks vec through 0 .. 2^N_IN-1, holds
// every vector for SETTLE cycles, then samples both implementation outputs
// in one extra cycle. It records the truth table of implementation A, the
// mismatch count, the first mismatching vector and an overall match flag.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     begin a sweep (only looked at while idle)
//   vec       stimulus to both implementations, vec[N_IN-1] is the MSB
//   r_a       output of implementation A
//   r_b       output of implementation B
//   busy      high from the cycle after start through the done cycle
//   done      one-cycle pulse at the end of a sweep
//   match     1 when A and B agreed on every vector of the last sweep
//   mism_vec  first vector where A and B differed, 0 if none
//   mism_cnt  number of vectors where A and B differed
//   table_a   bit i holds A sampled at vec == i
// ---------------------------------------------------------------------------
module tt_equiv_checker
  import tt_equiv_checker_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 r_a,
  input  logic                 r_b,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [N_IN-1:0]      mism_vec,
  output logic [N_IN:0]        mism_cnt,
  output logic [(1<<N_IN)-1:0] table_a
);

  // Refuse to elaborate with an input count the result widths were not
  // meant for.
  if (N_IN < 1 || N_IN > MAX_N_IN || SETTLE < 1) begin : g_badParam
    $error("tt_equiv_checker: N_IN must be 1..%0d and SETTLE >= 1", MAX_N_IN);
  end

  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

  state_t                r_state;
  logic [N_IN-1:0]       r_vec;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_match;
  logic [N_IN-1:0]       r_mismVec;
  logic [N_IN:0]         r_mismCnt;
  logic [(1<<N_IN)-1:0]  r_tableA;
  logic                  r_firstSeen;

  logic w_cntLoad;
  logic w_cntEnable;
  logic w_settleDone;

  // The settle count restarts whenever a new vector goes out: on the start
  // edge and on every sampling edge. It only runs while a vector is held.
  assign w_cntLoad   = ((r_state == ST_IDLE) && start) || (r_state == ST_SAMPLE);
  assign w_cntEnable = (r_state == ST_DRIVE);

  tt_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settleCounter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cntLoad),
    .i_enable   (w_cntEnable),
    .o_terminal (w_settleDone)
  );

  // Sweep sequencer. All outputs are registered here so the DUTs see a
  // glitch-free vec and the consumer sees stable results. The results of the
  // previous sweep are only cleared on the edge that accepts a new start, so
  // they remain readable for as long as the checker sits idle. The terminal
  // vector test happens before the increment, so vec never wraps within a
  // sweep and stays on the last vector through the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_match     <= 1'b1;
      r_mismVec   <= '0;
      r_mismCnt   <= '0;
      r_tableA    <= '0;
      r_firstSeen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_vec  <= '0;
          r_busy <= 1'b0;
          if (start) begin
            r_state     <= ST_DRIVE;
            r_busy      <= 1'b1;
            r_match     <= 1'b1;
            r_mismVec   <= '0;
            r_mismCnt   <= '0;
            r_tableA    <= '0;
            r_firstSeen <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (w_settleDone) begin
            r_state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          r_tableA[r_vec] <= r_a;
          if (r_a != r_b) begin
            r_match   <= 1'b0;
            r_mismCnt <= r_mismCnt + CNT_ONE;
            if (!r_firstSeen) begin
              r_mismVec   <= r_vec;
              r_firstSeen <= 1'b1;
            end
          end
          if (r_vec == VEC_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_vec   <= r_vec + VEC_ONE;
            r_state <= ST_DRIVE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec      = r_vec;
  assign busy     = r_busy;
  assign done     = r_done;
  assign match    = r_match;
  assign mism_vec = r_mismVec;
  assign mism_cnt = r_mismCnt;
  assign table_a  = r_tableA;

endmodule

// File: tb/tb_tt_equiv_checker.sv
// ---------------------------------------------------------------------------
// tb_tt_equiv_checker
// Self-checking bench for tt_equiv_checker. One instance runs with N_IN=2,
// SETTLE=1 and is fed by a selectable pair of reference functions; a second
// instance runs with SETTLE=3 on an XOR pair whose B side is disturbed while
// vectors are still settling.
// ---------------------------------------------------------------------------
module tb_tt_equiv_checker;

  typedef struct {
    int         mode;
    logic       expMatch;
    logic [2:0] expCnt;
    logic [1:0] expMismVec;
    logic [3:0] expTable;
  } sweepVec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] vec;
  logic       ra;
  logic       rb;
  logic       busy;
  logic       done;
  logic       match;
  logic [1:0] mismVec;
  logic [2:0] mismCnt;
  logic [3:0] tableA;

  logic       start3;
  logic [1:0] vec3;
  logic       ra3;
  logic       rb3;
  logic       busy3;
  logic       done3;
  logic       match3;
  logic [1:0] mismVec3;
  logic [2:0] mismCnt3;
  logic [3:0] tableA3;

  int         mode;
  logic       glitch3;
  int         vectorsApplied;
  int         miscompares;
  sweepVec_t  sweeps [6];

  // Implementation A of each function pair (x = vec[1], y = vec[0])
  function automatic logic fA(input int m, input logic [1:0] v);
    logic x;
    logic y;
    x = v[1];
    y = v[0];
    case (m)
      0, 1:    return ~x & y;
      2, 6:    return x ^ y;
      3:       return x | y;
      4:       return x;
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Implementation B of each function pair
  function automatic logic fB(input int m, input logic [1:0] v);
    logic x;
    logic y;
    x = v[1];
    y = v[0];
    case (m)
      0:       return ~x & y;
      1:       return ~(x | y);
      2:       return x & y;
      3:       return ~(x & y);
      4:       return x & y;
      5:       return 1'b0;
      6:       return x ^ y;
      default: return 1'b0;
    endcase
  endfunction

  assign ra  = fA(mode, vec);
  assign rb  = fB(mode, vec);
  assign ra3 = vec3[1] ^ vec3[0];
  assign rb3 = (vec3[1] ^ vec3[0]) ^ glitch3;

  tt_equiv_checker #(
    .N_IN   (2),
    .SETTLE (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .vec      (vec),
    .r_a      (ra),
    .r_b      (rb),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .mism_vec (mismVec),
    .mism_cnt (mismCnt),
    .table_a  (tableA)
  );

  tt_equiv_checker #(
    .N_IN   (2),
    .SETTLE (3)
  ) dut3 (
    .clk      (clk),
    .reset    (reset),
    .start    (start3),
    .vec      (vec3),
    .r_a      (ra3),
    .r_b      (rb3),
    .busy     (busy3),
    .done     (done3),
    .match    (match3),
    .mism_vec (mismVec3),
    .mism_cnt (mismCnt3),
    .table_a  (tableA3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int m, input logic s);
    mode  = m;
    start = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete sweep on the SETTLE=1 instance, started at edge 0; done is
  // expected in cycle 9 and the results are checked once it has passed.
  task automatic runSweep(input sweepVec_t sv, input logic chkSeq);
    int doneCyc;
    int doneN;
    doneCyc = -1;
    doneN   = 0;
    @(negedge clk);
    applyStimulus(sv.mode, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(sv.mode, 1'b0);
      if (done) begin
        doneN++;
        if (doneCyc < 0) doneCyc = k;
      end
      if (chkSeq && k <= 8) checkOutput("vec sequence", 32'(vec), 32'((k - 1) / 2));
      if (chkSeq && k <= 9) checkOutput("busy in sweep", 32'(busy), 32'd1);
    end
    checkOutput("done cycle", 32'(doneCyc), 32'd9);
    checkOutput("done pulses", 32'(doneN), 32'd1);
    checkOutput("busy after", 32'(busy), 32'd0);
    checkOutput("vec idle", 32'(vec), 32'd0);
    checkOutput("match", 32'(match), 32'(sv.expMatch));
    checkOutput("mism_cnt", 32'(mismCnt), 32'(sv.expCnt));
    checkOutput("mism_vec", 32'(mismVec), 32'(sv.expMismVec));
    checkOutput("table_a", 32'(tableA), 32'(sv.expTable));
  endtask

  // SETTLE=3 sweep: each vector is held four cycles, and B is corrupted in
  // every cycle except the sampling one.
  task automatic runSettle3;
    int doneCyc;
    int doneN;
    doneCyc = -1;
    doneN   = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start3 = 1'b0;
      glitch3 = (k <= 16) && (((k - 1) % 4) != 3);
      if (done3) begin
        doneN++;
        if (doneCyc < 0) doneCyc = k;
      end
      if (k <= 16) checkOutput("settle3 vec hold", 32'(vec3), 32'((k - 1) / 4));
    end
    glitch3 = 1'b0;
    checkOutput("settle3 done cycle", 32'(doneCyc), 32'd17);
    checkOutput("settle3 done pulses", 32'(doneN), 32'd1);
    checkOutput("settle3 table_a", 32'(tableA3), 32'h6);
    checkOutput("settle3 match", 32'(match3), 32'd1);
    checkOutput("settle3 mism_cnt", 32'(mismCnt3), 32'd0);
  endtask

  // Reset asserted in cycle 5 of a sweep: immediate return to reset values
  // and no done pulse, followed by a clean sweep.
  task automatic runResetMidSweep;
    int doneN;
    doneN = 0;
    @(negedge clk);
    applyStimulus(1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1, 1'b0);
    end
    checkOutput("pre-reset match", 32'(match), 32'd0);
    checkOutput("pre-reset table_a", 32'(tableA), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset vec", 32'(vec), 32'd0);
    checkOutput("mid reset match", 32'(match), 32'd1);
    checkOutput("mid reset table_a", 32'(tableA), 32'd0);
    checkOutput("mid reset mism_cnt", 32'(mismCnt), 32'd0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) doneN++;
    end
    checkOutput("no done after reset", 32'(doneN), 32'd0);
    runSweep(sweeps[1], 1'b0);
  endtask

  // Start pulses at cycle 3 and in the done cycle 9 are ignored; a start at
  // cycle 11 gives a second done at cycle 20.
  task automatic runRestartPulses;
    int doneFirst;
    int doneSecond;
    int doneN;
    doneFirst  = -1;
    doneSecond = -1;
    doneN      = 0;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      applyStimulus(0, (k == 3) || (k == 9) || (k == 11));
      if (done) begin
        doneN++;
        if (doneFirst < 0) doneFirst = k;
        else if (doneSecond < 0) doneSecond = k;
      end
      if (k == 4) checkOutput("no restart vec", 32'(vec), 32'd1);
      if (k == 10) checkOutput("idle after done", 32'(busy), 32'd0);
    end
    checkOutput("restart done pulses", 32'(doneN), 32'd2);
    checkOutput("restart first done", 32'(doneFirst), 32'd9);
    checkOutput("restart second done", 32'(doneSecond), 32'd20);
  endtask

  // Start held high continuously: the done cycle ignores it, the following
  // idle cycle accepts it.
  task automatic runHeldStart;
    int doneFirst;
    int doneSecond;
    int doneN;
    doneFirst  = -1;
    doneSecond = -1;
    doneN      = 0;
    @(negedge clk);
    applyStimulus(3, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 19) applyStimulus(3, 1'b0);
      if (done) begin
        doneN++;
        if (doneFirst < 0) doneFirst = k;
        else if (doneSecond < 0) doneSecond = k;
      end
      if (k == 10) checkOutput("held idle busy", 32'(busy), 32'd0);
      if (k == 11) checkOutput("held restart busy", 32'(busy), 32'd1);
    end
    checkOutput("held done pulses", 32'(doneN), 32'd2);
    checkOutput("held first done", 32'(doneFirst), 32'd9);
    checkOutput("held second done", 32'(doneSecond), 32'd19);
    checkOutput("held mism_cnt", 32'(mismCnt), 32'd2);
  endtask

  // Back-to-back sweeps: XOR vs AND, then B changed to XOR. Old results hold
  // until the new start edge, then clear and are recomputed.
  task automatic runBackToBack;
    int doneCyc;
    doneCyc = -1;
    runSweep(sweeps[2], 1'b0);
    @(negedge clk);
    applyStimulus(6, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("hold match", 32'(match), 32'd0);
    checkOutput("hold mism_cnt", 32'(mismCnt), 32'd3);
    checkOutput("hold mism_vec", 32'(mismVec), 32'd1);
    applyStimulus(6, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(6, 1'b0);
    checkOutput("cleared match", 32'(match), 32'd1);
    checkOutput("cleared mism_cnt", 32'(mismCnt), 32'd0);
    checkOutput("cleared mism_vec", 32'(mismVec), 32'd0);
    checkOutput("cleared table_a", 32'(tableA), 32'd0);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (done && doneCyc < 0) doneCyc = k;
    end
    checkOutput("sweep2 done cycle", 32'(doneCyc), 32'd9);
    checkOutput("sweep2 match", 32'(match), 32'd1);
    checkOutput("sweep2 table_a", 32'(tableA), 32'h6);
    checkOutput("sweep2 mism_cnt", 32'(mismCnt), 32'd0);
  endtask

  initial begin
    vectorsApplied = 0;
    miscompares    = 0;
    reset          = 1'b1;
    start          = 1'b0;
    start3         = 1'b0;
    mode           = 0;
    glitch3        = 1'b0;

    sweeps[0] = '{mode: 0, expMatch: 1'b1, expCnt: 3'd0, expMismVec: 2'd0, expTable: 4'b0010};
    sweeps[1] = '{mode: 1, expMatch: 1'b0, expCnt: 3'd2, expMismVec: 2'd0, expTable: 4'b0010};
    sweeps[2] = '{mode: 2, expMatch: 1'b0, expCnt: 3'd3, expMismVec: 2'd1, expTable: 4'b0110};
    sweeps[3] = '{mode: 3, expMatch: 1'b0, expCnt: 3'd2, expMismVec: 2'd0, expTable: 4'b1110};
    sweeps[4] = '{mode: 4, expMatch: 1'b0, expCnt: 3'd1, expMismVec: 2'd2, expTable: 4'b1100};
    sweeps[5] = '{mode: 5, expMatch: 1'b0, expCnt: 3'd4, expMismVec: 2'd0, expTable: 4'b1111};

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("reset vec", 32'(vec), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset match", 32'(match), 32'd1);
    checkOutput("reset mism_vec", 32'(mismVec), 32'd0);
    checkOutput("reset mism_cnt", 32'(mismCnt), 32'd0);
    checkOutput("reset table_a", 32'(tableA), 32'd0);

    applyStimulus(0, 1'b1);
    @(negedge clk);
    checkOutput("reset beats start", 32'(busy), 32'd0);
    applyStimulus(0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven sweeps");
    for (int i = 0; i < 6; i++) begin
      runSweep(sweeps[i], i == 0);
    end

    $display("[TB] settle=3 sweep with disturbed B");
    runSettle3();

    $display("[TB] reset mid-sweep");
    runResetMidSweep();

    $display("[TB] start while busy and in done cycle");
    runRestartPulses();

    $display("[TB] start held high");
    runHeldStart();

    $display("[TB] back-to-back sweeps");
    runBackToBack();

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
